// File: rtl/serial_adder_if.sv
// Operand/result bundle for the digit-serial adder.
// The master drives a request; the slave returns status and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, s, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, s, c_out, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB slice first,
// carry registered between slices; result registered once all slices are done.
//
// state  | meaning
// S_IDLE | waiting for start; result outputs hold the last completed operation
// S_BUSY | one DIGIT-bit slice added per edge
// S_DONE | result valid, one-cycle done pulse
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    serial_adder_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must divide WIDTH, WIDTH >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DIGIT:0]   slice_sum;
    logic [WIDTH-1:0] res_next;
    logic             msb_carry_in;

    assign slice_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};

    // Each new slice enters at the top so that after N slices the LSB slice sits at bit 0.
    if (DIGIT == WIDTH) begin : g_single
        assign res_next = slice_sum[DIGIT-1:0];
    end else begin : g_multi
        assign res_next = {slice_sum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    end

    // Carry into the top bit of the last slice, recovered from its sum bit.
    assign msb_carry_in = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_BUSY;
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.c_in;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_sum[DIGIT];
                res_d   = res_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    s_d     = res_next;
                    c_out_d = slice_sum[DIGIT];
                    ovf_d   = msb_carry_in ^ slice_sum[DIGIT];
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy  = (state_q == S_BUSY);
    assign bus.done  = (state_q == S_DONE);
    assign bus.s     = s_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule
